// File: rtl/irq_sched_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_sched_pkg : shared interrupt cause codes and scheduler states
// Rev 1.0
// ------------------------------------------------------------------
package irq_sched_pkg;

  localparam logic [30:0] IRQ_CODE_MSI = 31'd3;
  localparam logic [30:0] IRQ_CODE_MTI = 31'd7;
  localparam logic [30:0] IRQ_CODE_MEI = 31'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    TRAP = 2'd2,
    GAP  = 2'd3
  } irq_sched_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_sync : N-stage single-bit synchronizer with synchronous clear
// Rev 1.0
// ------------------------------------------------------------------
module irq_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign q_o = d_i;
    end else begin : g_flops
      logic [STAGES-1:0] sync_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= (sync_q << 1) | STAGES'(d_i);
        end
      end
      assign q_o = sync_q[STAGES-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/irq_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// irq_sched : interrupt sync, masking, priority and trap handshake
// Rev 1.0
// ------------------------------------------------------------------
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_GAP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        software_interrupt,
  input  logic        timer_interrupt,
  input  logic        external_interrupt,
  input  logic        debug_interrupt,
  input  logic        mstatus_mie,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        trap_take,
  input  logic        irq_ack,
  input  logic        mret,
  output logic        irq_req,
  output logic [30:0] irq_cause,
  output logic        irq_debug,
  output logic        mip_msip,
  output logic        mip_mtip,
  output logic        mip_meip,
  output logic        in_trap
);

  localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  // bit order: {debug, external, timer, software}
  logic [3:0] raw_lines;
  logic [3:0] sync_lines;

  assign raw_lines = {debug_interrupt, external_interrupt, timer_interrupt, software_interrupt};

  generate
    for (genvar i = 0; i < 4; i++) begin : g_sync
      irq_sync #(
        .STAGES (SYNC_STAGES)
      ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (raw_lines[i]),
        .q_o (sync_lines[i])
      );
    end
  endgenerate

  irq_sched_state_t state_q, state_d;
  logic [30:0]      cause_q, cause_d;
  logic             is_dbg_q, is_dbg_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             dbg_prev_q;
  logic             dbg_sticky_q, dbg_sticky_d;
  logic             dbg_clr;

  logic msi_elig, mti_elig, mei_elig, any_elig, latched_elig, dbg_rise;
  logic [30:0] pick_cause;
  logic        pick_dbg;

  assign msi_elig = mstatus_mie & mie_msie & sync_lines[0];
  assign mti_elig = mstatus_mie & mie_mtie & sync_lines[1];
  assign mei_elig = mstatus_mie & mie_meie & sync_lines[2];
  assign any_elig = dbg_sticky_q | mei_elig | msi_elig | mti_elig;
  assign dbg_rise = sync_lines[3] & ~dbg_prev_q;

  always_comb begin
    pick_dbg   = 1'b0;
    pick_cause = IRQ_CODE_MTI;
    if (dbg_sticky_q) begin
      pick_dbg   = 1'b1;
      pick_cause = '0;
    end else if (mei_elig) begin
      pick_cause = IRQ_CODE_MEI;
    end else if (msi_elig) begin
      pick_cause = IRQ_CODE_MSI;
    end
  end

  // A latched debug request never withdraws; the others follow their source.
  assign latched_elig = is_dbg_q
                      | ((cause_q == IRQ_CODE_MEI) & mei_elig)
                      | ((cause_q == IRQ_CODE_MSI) & msi_elig)
                      | ((cause_q == IRQ_CODE_MTI) & mti_elig);

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    is_dbg_d = is_dbg_q;
    gap_d    = gap_q;
    dbg_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_elig && !trap_take) begin
          state_d  = REQ;
          cause_d  = pick_cause;
          is_dbg_d = pick_dbg;
        end
      end
      REQ: begin
        if (trap_take && irq_ack) begin
          state_d = TRAP;
          dbg_clr = is_dbg_q;
        end else if (trap_take || !latched_elig) begin
          state_d = IDLE;
        end
      end
      TRAP: begin
        if (mret) begin
          if (MIN_GAP == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GAP_W'(MIN_GAP);
          end
        end
      end
      GAP: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q <= GAP_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fresh edge wins over the clear so it is not lost.
  assign dbg_sticky_d = dbg_rise ? 1'b1 : (dbg_clr ? 1'b0 : dbg_sticky_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      is_dbg_q     <= 1'b0;
      gap_q        <= '0;
      dbg_prev_q   <= 1'b0;
      dbg_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      is_dbg_q     <= is_dbg_d;
      gap_q        <= gap_d;
      dbg_prev_q   <= sync_lines[3];
      dbg_sticky_q <= dbg_sticky_d;
    end
  end

  assign irq_req   = (state_q == REQ);
  assign irq_cause = irq_req ? cause_q : '0;
  assign irq_debug = irq_req & is_dbg_q;
  assign in_trap   = (state_q == TRAP);
  assign mip_msip  = sync_lines[0];
  assign mip_mtip  = sync_lines[1];
  assign mip_meip  = sync_lines[2];

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_irq_sched : directed and randomized checks against a queue model
// Rev 1.0
// ------------------------------------------------------------------
module tb_irq_sched;

  localparam int SYNC = 2;
  localparam int GAPN = 3;

  logic clk = 1'b0;
  logic rst, sw, tm, ex, dbg, mie, msie, mtie, meie, tt, ack, mret;
  logic        irq_req, irq_debug, mip_msip, mip_mtip, mip_meip, in_trap;
  logic [30:0] irq_cause;

  always #5 clk = ~clk;

  irq_sched #(
    .SYNC_STAGES (SYNC),
    .MIN_GAP     (GAPN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .software_interrupt (sw),
    .timer_interrupt    (tm),
    .external_interrupt (ex),
    .debug_interrupt    (dbg),
    .mstatus_mie        (mie),
    .mie_msie           (msie),
    .mie_mtie           (mtie),
    .mie_meie           (meie),
    .trap_take          (tt),
    .irq_ack            (ack),
    .mret               (mret),
    .irq_req            (irq_req),
    .irq_cause          (irq_cause),
    .irq_debug          (irq_debug),
    .mip_msip           (mip_msip),
    .mip_mtip           (mip_mtip),
    .mip_meip           (mip_meip),
    .in_trap            (in_trap)
  );

  int total = 0;
  int bad   = 0;

  // Model: raw-sample history stands in for the synchronizers.
  logic [3:0]  hist[$];
  bit          m_req, m_dbg, m_handler, m_sticky, m_prev;
  logic [30:0] m_cause;
  int          m_gap;
  bit          chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [3:0] cur;
    bit e_sw, e_tm, e_ex, clr, rise;
    if (rst) begin
      m_req = 0; m_dbg = 0; m_handler = 0; m_sticky = 0; m_prev = 0;
      m_cause = '0; m_gap = 0;
      hist.delete();
      repeat (SYNC) hist.push_front(4'b0);
      return;
    end
    cur  = hist[SYNC-1];
    e_sw = cur[0] & mie & msie;
    e_tm = cur[1] & mie & mtie;
    e_ex = cur[2] & mie & meie;
    clr  = 0;
    if (m_req) begin
      if (tt && ack) begin
        m_req = 0; m_handler = 1; clr = m_dbg;
      end else if (tt) begin
        m_req = 0;
      end else if (!m_dbg && !((m_cause == 11 && e_ex) || (m_cause == 3 && e_sw) ||
                               (m_cause == 7 && e_tm))) begin
        m_req = 0;
      end
    end else if (m_handler) begin
      if (mret) begin
        m_handler = 0; m_gap = GAPN;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (!tt) begin
      if (m_sticky)  begin m_req = 1; m_dbg = 1; m_cause = 31'd0;  end
      else if (e_ex) begin m_req = 1; m_dbg = 0; m_cause = 31'd11; end
      else if (e_sw) begin m_req = 1; m_dbg = 0; m_cause = 31'd3;  end
      else if (e_tm) begin m_req = 1; m_dbg = 0; m_cause = 31'd7;  end
    end
    rise   = cur[3] & !m_prev;
    m_prev = cur[3];
    if (rise) m_sticky = 1;
    else if (clr) m_sticky = 0;
    hist.push_front({dbg, ex, tm, sw});
    void'(hist.pop_back());
  endtask

  always @(posedge clk) begin
    #2;
    if (chk_en) begin : compare_blk
      logic [3:0] s;
      s = hist[SYNC-1];
      cmp("irq_req",   32'(irq_req),   32'(m_req));
      cmp("irq_cause", 32'(irq_cause), 32'(m_req ? m_cause : 31'd0));
      cmp("irq_debug", 32'(irq_debug), 32'(m_req & m_dbg));
      cmp("in_trap",   32'(in_trap),   32'(m_handler));
      cmp("mip_msip",  32'(mip_msip),  32'(s[0]));
      cmp("mip_mtip",  32'(mip_mtip),  32'(s[1]));
      cmp("mip_meip",  32'(mip_meip),  32'(s[2]));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (SYNC) hist.push_front(4'b0);
    rst = 1; sw = 0; tm = 0; ex = 0; dbg = 0; mie = 0; msie = 0; mtie = 0; meie = 0;
    tt = 0; ack = 0; mret = 0;
    chk_en = 1'b1;
    step(2);
    cmp("lit_rst_req",   32'(irq_req),   32'd0);
    cmp("lit_rst_cause", 32'(irq_cause), 32'd0);
    cmp("lit_rst_trap",  32'(in_trap),   32'd0);
    rst = 0;

    // Timer: sync latency, then request one cycle later.
    mie = 1; msie = 1; mtie = 1; meie = 1; tm = 1;
    step(1); cmp("lit_mtip_early", 32'(mip_mtip), 32'd0);
    step(1); cmp("lit_mtip_sync",  32'(mip_mtip), 32'd1);
    cmp("lit_req_not_yet", 32'(irq_req), 32'd0);
    step(1); cmp("lit_req_mti",    32'(irq_req), 32'd1);
    cmp("lit_cause_mti", 32'(irq_cause), 32'd7);

    // Higher priority arrival does not preempt.
    ex = 1; step(3);
    cmp("lit_no_preempt", 32'(irq_cause), 32'd7);
    tt = 1; ack = 1; step(1); tt = 0; ack = 0;
    cmp("lit_in_trap", 32'(in_trap), 32'd1);
    dbg = 1; step(4);
    cmp("lit_trap_no_req", 32'(irq_req), 32'd0);
    mret = 1; step(1); mret = 0;
    cmp("lit_mret_trap", 32'(in_trap), 32'd0);
    step(3); cmp("lit_gap_hold", 32'(irq_req), 32'd0);
    step(1); cmp("lit_gap_req",  32'(irq_req), 32'd1);
    cmp("lit_dbg_flag",  32'(irq_debug), 32'd1);
    cmp("lit_dbg_cause", 32'(irq_cause), 32'd0);
    tt = 1; ack = 1; step(1); tt = 0; ack = 0; dbg = 0;
    mret = 1; step(1); mret = 0;
    step(4); cmp("lit_mei_after", 32'(irq_cause), 32'd11);

    // Non-ack trap drops the request; withdraw on mask.
    tt = 1; ack = 0; step(1); tt = 0;
    cmp("lit_nack_drop", 32'(irq_req), 32'd0);
    step(1); cmp("lit_rearb", 32'(irq_req), 32'd1);
    ex = 0; tm = 0; sw = 1; step(4);
    cmp("lit_msi_cause", 32'(irq_cause), 32'd3);
    msie = 0; step(1);
    cmp("lit_withdraw", 32'(irq_req), 32'd0);
    cmp("lit_msip_kept", 32'(mip_msip), 32'd1);

    // Global disable; debug still gets through.
    mie = 0; msie = 1; ex = 1; step(5);
    cmp("lit_mie_off", 32'(irq_req), 32'd0);
    dbg = 1; step(4);
    cmp("lit_dbg_req", 32'(irq_debug), 32'd1);
    tt = 1; ack = 1; step(1); tt = 0; ack = 0;
    dbg = 0; step(3); dbg = 1; step(4);
    rst = 1; step(1);
    cmp("lit_rst_trap_req",  32'(irq_req), 32'd0);
    cmp("lit_rst_trap_trap", 32'(in_trap), 32'd0);
    cmp("lit_rst_trap_meip", 32'(mip_meip), 32'd0);
    rst = 0; dbg = 0; step(8);
    cmp("lit_no_stale_dbg", 32'(irq_req), 32'd0);

    // Randomized phase; levels toggle occasionally so requests persist.
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7)  == 0) sw   = ~sw;
      if ($urandom_range(0, 7)  == 0) tm   = ~tm;
      if ($urandom_range(0, 7)  == 0) ex   = ~ex;
      if ($urandom_range(0, 11) == 0) dbg  = ~dbg;
      if ($urandom_range(0, 15) == 0) mie  = ~mie;
      if ($urandom_range(0, 15) == 0) msie = ~msie;
      if ($urandom_range(0, 15) == 0) mtie = ~mtie;
      if ($urandom_range(0, 15) == 0) meie = ~meie;
      tt   = ($urandom_range(0, 5) == 0);
      ack  = 1'($urandom_range(0, 1));
      mret = ($urandom_range(0, 7) == 0);
      step(1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
